// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NREQ response requesters.
// Optional idle-owner timeout is compiled in with TX_ARB_TIMEOUT_EN.
module tx_arbiter #(
  parameter int NREQ        = 2,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   req_data,
  input  logic [NREQ-1:0]     req_send,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     req_busy,
  output logic [7:0]          tx_data,
  output logic                tx_send,
  input  logic                tx_busy,
  output logic [2:0]          owner_id,
  output logic                drop_flag,
  output logic                timeout_flag
);

  // state | meaning
  // IDLE  | no grant; pick a round-robin winner when any req is high
  // OWN   | owner_id holds the grant; its strobes pass straight to uart_tx
  // DRAIN | grant dropped; wait for uart_tx to finish the last byte
  typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_t;

  state_t          state;
  logic [2:0]      last_owner;
  logic [2:0]      winner;
  logic            req_own;
  logic            send_own;
  logic [7:0]      data_own;
  logic [NREQ-1:0] foreign_send;
  logic            idle_expired;

  always_comb begin
    req_own  = 1'b0;
    send_own = 1'b0;
    data_own = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_id == 3'(i)) begin
        req_own  = req[i];
        send_own = req_send[i];
        data_own = req_data[8*i +: 8];
      end
    end
  end

  // Search from last_owner+1 upward; the first hit wins.
  always_comb begin
    winner = last_owner;
    for (int k = NREQ; k >= 1; k--) begin
      for (int j = 0; j < NREQ; j++) begin
        if ((j == (int'(last_owner) + k) % NREQ) && req[j]) winner = 3'(j);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      foreign_send[i] = req_send[i] & ~((state == OWN) && (owner_id == 3'(i)));
    end
  end

  assign tx_send  = (state == OWN) & send_own & ~rst;
  assign tx_data  = (state == OWN) ? data_own : 8'h00;
  assign req_busy = {NREQ{tx_busy}} | ~gnt;

`ifdef TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] idle_cnt;

  assign idle_expired = (idle_cnt >= CW'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (rst || state != OWN) begin
      idle_cnt <= '0;
    end else if (send_own) begin
      idle_cnt <= '0;
    end else if (!tx_busy && !idle_expired) begin
      idle_cnt <= idle_cnt + CW'(1);
    end
  end
`else
  logic unused_timeout;
  assign idle_expired   = 1'b0;
  assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      gnt          <= '0;
      owner_id     <= '0;
      last_owner   <= 3'(NREQ - 1);
      drop_flag    <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      if (|foreign_send) drop_flag <= 1'b1;
      case (state)
        IDLE: begin
          if (|req) begin
            state    <= OWN;
            owner_id <= winner;
            for (int i = 0; i < NREQ; i++) gnt[i] <= (winner == 3'(i));
          end
        end
        OWN: begin
          if (!req_own) begin
            state <= DRAIN;
            gnt   <= '0;
          end else if (idle_expired) begin
            state        <= DRAIN;
            gnt          <= '0;
            timeout_flag <= 1'b1;
          end
        end
        DRAIN: begin
          // last_owner updates only here so a quick re-request queues behind others
          if (!tx_busy) begin
            state      <= IDLE;
            last_owner <= owner_id;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: directed scenarios plus a randomized
// run compared against a cycle-level behavioural model.
module tb_tx_arbiter;
  localparam int NREQ = 2;
  localparam int TO   = 100;

  logic             clk = 1'b0;
  logic             rst;
  logic [NREQ-1:0]  req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]  req_send;
  logic [NREQ-1:0]  gnt;
  logic [NREQ-1:0]  req_busy;
  logic [7:0]       tx_data;
  logic             tx_send;
  logic             tx_busy;
  logic [2:0]       owner_id;
  logic             drop_flag;
  logic             timeout_flag;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  int m_own, m_prev, m_last, m_idle;
  bit m_drain, m_drop, m_to;

  tx_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_send(req_send),
    .gnt(gnt), .req_busy(req_busy), .tx_data(tx_data), .tx_send(tx_send),
    .tx_busy(tx_busy), .owner_id(owner_id), .drop_flag(drop_flag),
    .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; req_send = '0; req_data = '0; tx_busy = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic model_reset();
    m_own = -1; m_prev = 0; m_last = NREQ - 1; m_idle = 0;
    m_drain = 0; m_drop = 0; m_to = 0;
  endtask

  task automatic model_tick(input bit r, input bit [NREQ-1:0] rq,
                            input bit [NREQ-1:0] snd, input bit busy);
    bit leave, expired;
    int w;
    if (r) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NREQ; i++) if (snd[i] && m_own != i) m_drop = 1;
    if (m_own >= 0) begin
      leave   = !rq[m_own];
      expired = 0;
`ifdef TX_ARB_TIMEOUT_EN
      expired = (m_idle >= TO);
`endif
      if (leave || expired) begin
        if (!leave) m_to = 1;
        m_prev = m_own; m_own = -1; m_drain = 1; m_idle = 0;
      end else if (snd[m_own]) m_idle = 0;
      else if (!busy) m_idle++;
    end else if (m_drain) begin
      if (!busy) begin m_drain = 0; m_last = m_prev; end
    end else if (rq != 0) begin
      w = -1;
      for (int k = 1; k <= NREQ; k++) if (w < 0 && rq[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
      m_own = w;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b11; req_send = 2'b11; req_data = 16'hFFFF; tx_busy = 1'b0;
    tick(); tick();
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt: got=%b want=00", gnt); end
    total++; if (owner_id !== 3'd0) begin bad++; $display("FAIL reset_owner: got=%0d want=0", owner_id); end
    total++; if (drop_flag !== 1'b0) begin bad++; $display("FAIL reset_drop: got=%b want=0", drop_flag); end
    total++; if (timeout_flag !== 1'b0) begin bad++; $display("FAIL reset_timeout: got=%b want=0", timeout_flag); end
    total++; if (tx_send !== 1'b0) begin bad++; $display("FAIL reset_tx_send: got=%b want=0", tx_send); end
    total++; if (req_busy !== 2'b11) begin bad++; $display("FAIL reset_req_busy: got=%b want=11", req_busy); end
    rst = 1'b0; req = '0; req_send = '0;
  endtask

  task automatic test_first_grant();
    do_reset();
    for (int i = 0; i < 9; i++) tick();
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL idle_gnt: got=%b want=00", gnt); end
    req = 2'b01;
    tick();
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL first_gnt: got=%b want=01", gnt); end
    total++; if (owner_id !== 3'd0) begin bad++; $display("FAIL first_owner: got=%0d want=0", owner_id); end
    req_data[7:0] = 8'h07; req_send = 2'b01;
    #1;
    total++; if (tx_send !== 1'b1 || tx_data !== 8'h07)
      begin bad++; $display("FAIL first_byte: send=%b data=%h want send=1 data=07", tx_send, tx_data); end
    tick();
    req_send = '0; req = '0;
    tick(); tick();
  endtask

  task automatic test_frame_order();
    logic [7:0] b;
    do_reset();
    req = 2'b11;
    tick();
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL frame_first_gnt: got=%b want=01", gnt); end
    for (int n = 0; n < 40; n++) begin
      b = 8'(n * 7 + 3);
      req_data = {8'($urandom), b};
      req_send = 2'b01;
      #1;
      total++; if (tx_send !== 1'b1 || tx_data !== b)
        begin bad++; $display("FAIL frame_byte%0d: send=%b data=%h want send=1 data=%h", n, tx_send, tx_data, b); end
      tick();
      req_send = 2'b00;
      #1;
      total++; if (tx_send !== 1'b0) begin bad++; $display("FAIL frame_extra%0d: send=%b want=0", n, tx_send); end
      for (int g = 0; g < int'($urandom_range(2)); g++) tick();
    end
    req = 2'b10; tx_busy = 1'b1;
    tick();
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL frame_release: got=%b want=00", gnt); end
    req = 2'b11; tx_busy = 1'b0;
    tick();
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL frame_idle: got=%b want=00", gnt); end
    tick();
    total++; if (gnt !== 2'b10 || owner_id !== 3'd1)
      begin bad++; $display("FAIL frame_next_owner: gnt=%b id=%0d want gnt=10 id=1", gnt, owner_id); end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_drop();
    do_reset();
    req = 2'b01;
    tick();
    total++; if (drop_flag !== 1'b0) begin bad++; $display("FAIL drop_pre: got=%b want=0", drop_flag); end
    req_data[15:8] = 8'h55; req_send = 2'b10;
    #1;
    total++; if (tx_send !== 1'b0) begin bad++; $display("FAIL drop_tx_send: got=%b want=0", tx_send); end
    tick();
    req_send = '0;
    total++; if (drop_flag !== 1'b1) begin bad++; $display("FAIL drop_set: got=%b want=1", drop_flag); end
    for (int i = 0; i < 5; i++) tick();
    total++; if (drop_flag !== 1'b1) begin bad++; $display("FAIL drop_sticky: got=%b want=1", drop_flag); end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_drain_busy();
    int leaks;
    do_reset();
    req = 2'b11;
    tick();
    tx_busy = 1'b1; req = 2'b10;
    tick();
    leaks = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (gnt !== 2'b00) leaks++;
    end
    total++; if (leaks != 0) begin bad++; $display("FAIL drain_hold: cycles_with_gnt=%0d want=0", leaks); end
    tx_busy = 1'b0;
    tick();
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL drain_exit: got=%b want=00", gnt); end
    tick();
    total++; if (gnt !== 2'b10) begin bad++; $display("FAIL drain_regrant: got=%b want=10", gnt); end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    int lost;
    do_reset();
    req = 2'b01; tx_busy = 1'b0;
    tick();
    lost = 0;
`ifdef TX_ARB_TIMEOUT_EN
    for (int i = 0; i < TO; i++) begin
      tick();
      if (gnt !== 2'b01) lost++;
    end
    total++; if (lost != 0) begin bad++; $display("FAIL timeout_early: cycles_lost=%0d want=0", lost); end
    tick();
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL timeout_revoke: got=%b want=00", gnt); end
    total++; if (timeout_flag !== 1'b1) begin bad++; $display("FAIL timeout_flag: got=%b want=1", timeout_flag); end
`else
    for (int i = 0; i < 10000; i++) begin
      tick();
      if (gnt !== 2'b01) lost++;
    end
    total++; if (lost != 0) begin bad++; $display("FAIL hold_no_timeout: cycles_lost=%0d want=0", lost); end
    total++; if (timeout_flag !== 1'b0) begin bad++; $display("FAIL timeout_flag_tied: got=%b want=0", timeout_flag); end
`endif
    req = '0;
    tick(); tick();
  endtask

  task automatic test_reset_midframe();
    do_reset();
    req = 2'b10;
    tick();
    total++; if (gnt !== 2'b10) begin bad++; $display("FAIL mid_gnt: got=%b want=10", gnt); end
    req_data[15:8] = 8'hAA; req_send = 2'b10;
    #1;
    total++; if (tx_send !== 1'b1 || tx_data !== 8'hAA)
      begin bad++; $display("FAIL mid_send: send=%b data=%h want send=1 data=aa", tx_send, tx_data); end
    rst = 1'b1;
    #1;
    total++; if (tx_send !== 1'b0) begin bad++; $display("FAIL mid_rst_send: got=%b want=0", tx_send); end
    tick();
    total++; if (gnt !== 2'b00 || tx_send !== 1'b0)
      begin bad++; $display("FAIL mid_rst_gnt: gnt=%b send=%b want gnt=00 send=0", gnt, tx_send); end
    rst = 1'b0; req = 2'b11; req_send = '0;
    tick();
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL mid_after_rst: got=%b want=01", gnt); end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_random();
    logic [NREQ-1:0] exp_gnt;
    bit exp_send;
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      model_tick(rst, req, req_send, tx_busy);
      exp_gnt = (m_own >= 0) ? NREQ'(1 << m_own) : '0;
      total++; if (gnt !== exp_gnt) begin bad++; $display("FAIL rnd_gnt c=%0d: got=%b want=%b", c, gnt, exp_gnt); end
      total++; if (drop_flag !== m_drop) begin bad++; $display("FAIL rnd_drop c=%0d: got=%b want=%b", c, drop_flag, m_drop); end
      total++; if (timeout_flag !== m_to) begin bad++; $display("FAIL rnd_timeout c=%0d: got=%b want=%b", c, timeout_flag, m_to); end
      if (m_own >= 0) begin
        total++; if (owner_id !== 3'(m_own)) begin bad++; $display("FAIL rnd_owner c=%0d: got=%0d want=%0d", c, owner_id, m_own); end
      end
      rst = ($urandom_range(499) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(19) == 0) req[i] = ~req[i];
        req_send[i] = req[i] ? ($urandom_range(9) < 4) : ($urandom_range(99) < 3);
      end
      req_data = 16'($urandom);
      tx_busy  = ($urandom_range(9) < 3);
      #1;
      exp_send = !rst && (m_own >= 0) && req_send[m_own];
      total++; if (tx_send !== exp_send) begin bad++; $display("FAIL rnd_tx_send c=%0d: got=%b want=%b", c, tx_send, exp_send); end
      if (exp_send) begin
        total++; if (tx_data !== req_data[8*m_own +: 8])
          begin bad++; $display("FAIL rnd_tx_data c=%0d: got=%h want=%h", c, tx_data, req_data[8*m_own +: 8]); end
      end
      total++; if (req_busy !== ({NREQ{tx_busy}} | ~exp_gnt))
        begin bad++; $display("FAIL rnd_req_busy c=%0d: got=%b want=%b", c, req_busy, {NREQ{tx_busy}} | ~exp_gnt); end
    end
    rst = 1'b0; req = '0; req_send = '0;
  endtask

  initial begin
    rst = 1'b1; req = '0; req_send = '0; req_data = '0; tx_busy = 1'b0;
    test_reset();
    test_first_grant();
    test_frame_order();
    test_drop();
    test_drain_busy();
    test_timeout();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
